// File: rtl/attack_shot_ctrl.sv
// Shot controller for the battleship attack stage.
// Debounces the confirm button, validates the attack coordinate, records each shot in the
// attack map, keeps saturating shot/hit counters and raises game_over once every ship cell
// has been hit. All outputs are registered.
module attack_shot_ctrl #(
  parameter int unsigned DEB_TICKS = 4,
  parameter int unsigned CNT_W     = 6
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_tick,
  input  logic             i_btn_n,
  input  logic [1:0]       i_mode,
  input  logic [5:0]       i_coord,
  input  logic [34:0]      i_ship_map,
  output logic [34:0]      o_att_map,
  output logic             o_shot_pls,
  output logic             o_hit,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_shots,
  output logic [CNT_W-1:0] o_hits,
  output logic             o_game_over,
  output logic [1:0]       o_rgb
);

  localparam int unsigned DebW = $clog2(DEB_TICKS + 1);

  localparam logic [1:0] ModeSetup  = 2'b00;
  localparam logic [1:0] ModeAttack = 2'b01;

  localparam logic [1:0] RgbHit  = 2'b01;
  localparam logic [1:0] RgbMiss = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCheck,
    StUpdate,
    StRelease,
    StOver
  } state_e;

  // ---------------------------------------------------------------------------
  // Button debounce
  // ---------------------------------------------------------------------------
  logic [DebW-1:0] r_deb_cnt;
  logic [DebW-1:0] w_deb_cnt_d;
  logic            r_btn_pressed;
  logic            w_btn_pressed_d;
  logic            w_sample_pressed;
  logic            w_press_evt;

  assign w_sample_pressed = ~i_btn_n;

  // Count consecutive differing tick samples; accept the new level after DEB_TICKS of them.
  always_comb begin
    w_deb_cnt_d     = r_deb_cnt;
    w_btn_pressed_d = r_btn_pressed;
    w_press_evt     = 1'b0;
    if (i_tick) begin
      if (w_sample_pressed != r_btn_pressed) begin
        if (r_deb_cnt == DebW'(DEB_TICKS - 1)) begin
          w_btn_pressed_d = w_sample_pressed;
          w_deb_cnt_d     = '0;
          // Only the released->pressed transition is a press event.
          w_press_evt     = w_sample_pressed;
        end else begin
          w_deb_cnt_d = r_deb_cnt + DebW'(1);
        end
      end else begin
        w_deb_cnt_d = '0;
      end
    end
  end

  // Debounce state register.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_deb_cnt     <= '0;
      r_btn_pressed <= 1'b0;
    end else begin
      r_deb_cnt     <= w_deb_cnt_d;
      r_btn_pressed <= w_btn_pressed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Coordinate decode
  // ---------------------------------------------------------------------------
  logic [2:0]  w_col;
  logic [2:0]  w_line;
  logic [5:0]  w_index;
  logic [5:0]  w_bit_pos;
  logic        w_coord_bad;
  logic [34:0] w_cell_mask;
  logic        w_cell_repeat;

  assign w_col       = i_coord[5:3];
  assign w_line      = i_coord[2:0];
  assign w_index     = 6'(w_line) * 6'd5 + 6'(w_col);
  assign w_coord_bad = (w_col > 3'd4) || (w_line > 3'd6);
  // Cell (line, col) lives at bit 34-index; an out-of-range coordinate selects no cell.
  assign w_bit_pos   = 6'd34 - w_index;
  assign w_cell_mask = w_coord_bad ? '0 : (35'd1 << w_bit_pos);
  assign w_cell_repeat = |(o_att_map & w_cell_mask);

  // ---------------------------------------------------------------------------
  // Control FSM and shot datapath
  // ---------------------------------------------------------------------------
  state_e            r_state;
  state_e            w_state_d;
  logic [34:0]       r_cell_mask;
  logic [34:0]       w_cell_mask_d;
  logic              r_invalid;
  logic              w_invalid_d;
  logic              r_repeat;
  logic              w_repeat_d;
  logic [34:0]       r_ship_map;
  logic [34:0]       w_ship_map_d;
  logic              r_upd;
  logic              w_upd_d;
  logic [34:0]       r_att_map;
  logic [34:0]       w_att_map_d;
  logic              r_shot_pls;
  logic              w_shot_pls_d;
  logic              r_hit;
  logic              w_hit_d;
  logic              r_fault;
  logic              w_fault_d;
  logic [CNT_W-1:0]  r_shots;
  logic [CNT_W-1:0]  w_shots_d;
  logic [CNT_W-1:0]  r_hits;
  logic [CNT_W-1:0]  w_hits_d;
  logic              r_game_over;
  logic              w_game_over_d;
  logic [1:0]        r_rgb;
  logic [1:0]        w_rgb_d;
  logic              w_attack;
  logic              w_clear;
  logic              w_all_sunk;
  logic              w_ship_hit;

  assign w_attack   = (i_mode == ModeAttack);
  // Evaluated in the cycle after a valid update, against the ship map latched with that shot.
  assign w_all_sunk = ((r_ship_map & ~r_att_map) == '0) && (r_ship_map != '0);
  assign w_ship_hit = |(i_ship_map & r_cell_mask);

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    w_state_d     = r_state;
    w_cell_mask_d = r_cell_mask;
    w_invalid_d   = r_invalid;
    w_repeat_d    = r_repeat;
    w_ship_map_d  = r_ship_map;
    w_upd_d       = 1'b0;
    w_att_map_d   = r_att_map;
    w_shot_pls_d  = 1'b0;
    w_hit_d       = r_hit;
    w_fault_d     = r_fault;
    w_shots_d     = r_shots;
    w_hits_d      = r_hits;
    w_game_over_d = r_game_over;
    w_rgb_d       = r_rgb;
    w_clear       = 1'b0;

    if (r_upd) begin
      w_game_over_d = w_all_sunk;
    end

    unique case (r_state)
      StIdle: begin
        if (i_mode == ModeSetup) begin
          w_clear = 1'b1;
        end else if (w_attack) begin
          w_state_d = StArmed;
        end
      end
      StArmed: begin
        if (!w_attack) begin
          w_state_d = StIdle;
        end else if (w_press_evt) begin
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        if (!w_attack) begin
          w_state_d = StIdle;
        end else begin
          w_cell_mask_d = w_cell_mask;
          w_invalid_d   = w_coord_bad;
          w_repeat_d    = w_cell_repeat;
          w_state_d     = StUpdate;
        end
      end
      StUpdate: begin
        if (!w_attack) begin
          w_state_d = StIdle;
        end else begin
          w_state_d = StRelease;
          if (r_invalid || r_repeat) begin
            w_fault_d = 1'b1;
            w_hit_d   = 1'b0;
            w_rgb_d   = RgbMiss;
          end else begin
            w_att_map_d  = r_att_map | r_cell_mask;
            w_fault_d    = 1'b0;
            w_shot_pls_d = 1'b1;
            w_upd_d      = 1'b1;
            w_ship_map_d = i_ship_map;
            w_shots_d    = (r_shots == '1) ? r_shots : r_shots + CNT_W'(1);
            if (w_ship_hit) begin
              w_hit_d  = 1'b1;
              w_hits_d = (r_hits == '1) ? r_hits : r_hits + CNT_W'(1);
              w_rgb_d  = RgbHit;
            end else begin
              w_hit_d = 1'b0;
              w_rgb_d = RgbMiss;
            end
          end
        end
      end
      StRelease: begin
        if (!w_attack) begin
          w_state_d = StIdle;
        end else if (!r_btn_pressed) begin
          // game_over may still be in flight from the shot just recorded.
          w_state_d = (r_game_over || (r_upd && w_all_sunk)) ? StOver : StArmed;
        end
      end
      StOver: begin
        if (i_mode == ModeSetup) begin
          w_clear   = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_clear) begin
      w_att_map_d   = '0;
      w_ship_map_d  = '0;
      w_hit_d       = 1'b0;
      w_fault_d     = 1'b0;
      w_shots_d     = '0;
      w_hits_d      = '0;
      w_game_over_d = 1'b0;
      w_rgb_d       = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Shot datapath and output registers; reset overrides any update in progress.
  always_ff @(posedge i_clk) begin
    if (!i_clr) begin
      r_cell_mask <= '0;
      r_invalid   <= 1'b0;
      r_repeat    <= 1'b0;
      r_ship_map  <= '0;
      r_upd       <= 1'b0;
      r_att_map   <= '0;
      r_shot_pls  <= 1'b0;
      r_hit       <= 1'b0;
      r_fault     <= 1'b0;
      r_shots     <= '0;
      r_hits      <= '0;
      r_game_over <= 1'b0;
      r_rgb       <= '0;
    end else begin
      r_cell_mask <= w_cell_mask_d;
      r_invalid   <= w_invalid_d;
      r_repeat    <= w_repeat_d;
      r_ship_map  <= w_ship_map_d;
      r_upd       <= w_upd_d;
      r_att_map   <= w_att_map_d;
      r_shot_pls  <= w_shot_pls_d;
      r_hit       <= w_hit_d;
      r_fault     <= w_fault_d;
      r_shots     <= w_shots_d;
      r_hits      <= w_hits_d;
      r_game_over <= w_game_over_d;
      r_rgb       <= w_rgb_d;
    end
  end

  assign o_att_map   = r_att_map;
  assign o_shot_pls  = r_shot_pls;
  assign o_hit       = r_hit;
  assign o_fault     = r_fault;
  assign o_shots     = r_shots;
  assign o_hits      = r_hits;
  assign o_game_over = r_game_over;
  assign o_rgb       = r_rgb;

endmodule
